// File: rtl/avalon_bus_arbiter_if.sv
// Bus bundle between the two Avalon masters, the arbiter and the shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface avalon_bus_arbiter_if;
    logic [31:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_byteenable;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;

    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;

    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;

    logic [1:0]  grant;
    logic        timeout_err;

    modport slave (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  s_waitrequest, s_readdata,
        output m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata,
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        output grant, timeout_err
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output s_waitrequest, s_readdata,
        input  m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata,
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        input  grant, timeout_err
    );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-master round-robin arbiter for one shared Avalon slave, with a stall timeout
// that aborts a hung access and returns all-ones read data to the stalled master.
//
// state | meaning
// IDLE  | no owner; arbitrate among requesters
// GNT0  | master 0 (CPU) owns the slave
// GNT1  | master 1 (instruction loader) owns the slave
module avalon_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    avalon_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [7:0]  stall_q, stall_d;
    logic        terr_q, terr_d;
    logic [1:0]  grant_q, grant_d;

    logic        req0, req1, gnt_req, timeout_hit;

    assign req0        = bus.m0_read | bus.m0_write;
    assign req1        = bus.m1_read | bus.m1_write;
    assign gnt_req     = (state_q == GNT0) ? req0 : req1;
    assign timeout_hit = (state_q != IDLE) && (stall_q == 8'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            stall_q <= 8'd0;
            terr_q  <= 1'b0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            terr_q  <= terr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                stall_d = 8'd0;
                if (req0 && req1)
                    state_d = ptr_q ? GNT1 : GNT0;
                else if (req0)
                    state_d = GNT0;
                else if (req1)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                // Abort outranks everything; a dropped request leaves the pointer alone.
                if (timeout_hit) begin
                    state_d = IDLE;
                    ptr_d   = (state_q == GNT0);
                    terr_d  = 1'b1;
                end else if (!gnt_req) begin
                    state_d = IDLE;
                end else if (!bus.s_waitrequest) begin
                    state_d = IDLE;
                    ptr_d   = (state_q == GNT0);
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        grant_d = 2'b00;
        if (state_d == GNT0) grant_d = 2'b01;
        if (state_d == GNT1) grant_d = 2'b10;
    end

    always_comb begin
        bus.s_address      = 32'h0;
        bus.s_writedata    = 32'h0;
        bus.s_byteenable   = 4'h0;
        bus.s_read         = 1'b0;
        bus.s_write        = 1'b0;
        bus.m0_waitrequest = 1'b1;
        bus.m0_readdata    = 32'h0;
        bus.m1_waitrequest = 1'b1;
        bus.m1_readdata    = 32'h0;
        case (state_q)
            GNT0: begin
                bus.s_address      = bus.m0_address;
                bus.s_writedata    = bus.m0_writedata;
                bus.s_byteenable   = bus.m0_byteenable;
                bus.s_write        = bus.m0_write & ~timeout_hit;
                bus.s_read         = bus.m0_read & ~bus.m0_write & ~timeout_hit;
                bus.m0_waitrequest = timeout_hit ? 1'b0 : bus.s_waitrequest;
                bus.m0_readdata    = timeout_hit ? 32'hFFFF_FFFF : bus.s_readdata;
            end
            GNT1: begin
                bus.s_address      = bus.m1_address;
                bus.s_writedata    = bus.m1_writedata;
                bus.s_byteenable   = bus.m1_byteenable;
                bus.s_write        = bus.m1_write & ~timeout_hit;
                bus.s_read         = bus.m1_read & ~bus.m1_write & ~timeout_hit;
                bus.m1_waitrequest = timeout_hit ? 1'b0 : bus.s_waitrequest;
                bus.m1_readdata    = timeout_hit ? 32'hFFFF_FFFF : bus.s_readdata;
            end
            default: ;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.timeout_err = terr_q | timeout_hit;

endmodule
